// File: rtl/pool_sched_pkg.sv
// Shared types for the pooling-layer scheduler: FSM encoding, command layout,
// legal feature lengths and the expected-beat arithmetic.
package pool_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4,
    S_REPORT    = 3'd5
  } state_t;

  localparam int FLEN_W = 6;
  localparam int CH_W   = 9;
  localparam int EXP_W  = 16;

  localparam logic [FLEN_W-1:0] FLEN_4  = 6'd4;
  localparam logic [FLEN_W-1:0] FLEN_8  = 6'd8;
  localparam logic [FLEN_W-1:0] FLEN_16 = 6'd16;
  localparam logic [FLEN_W-1:0] FLEN_32 = 6'd32;

  typedef struct packed {
    logic [FLEN_W-1:0] flen;
    logic [CH_W-1:0]   in_channel;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic cmd_legal(cmd_t c);
    return (c.flen inside {FLEN_4, FLEN_8, FLEN_16, FLEN_32}) && (c.in_channel != '0);
  endfunction

  // (flen*flen/16)*in_channel; largest legal case is 64*511 = 32704.
  function automatic logic [EXP_W-1:0] calc_expected(cmd_t c);
    logic [11:0] sq;
    sq = 12'(c.flen) * 12'(c.flen);
    return EXP_W'(sq[11:4]) * EXP_W'(c.in_channel);
  endfunction

endpackage

// File: rtl/pool_sched_fifo.sv
// Command queue: single-clock FIFO with combinational head read.
// A push while full is ignored; the owner gates push with !full.
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pool_sched.sv
// Layer scheduler for the pooling datapath: queues layer commands, drives a
// two-phase start/done handshake and audits the output stream per layer.
module pool_sched
  import pool_sched_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [FLEN_W-1:0] cmd_flen,
  input  logic [CH_W-1:0]   cmd_in_channel,
  output logic              pool_start,
  input  logic              pool_done,
  output logic [FLEN_W-1:0] flen,
  output logic [CH_W-1:0]   in_channel,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tlast,
  input  logic              err_clr,
  output logic              busy,
  output logic              irq,
  output logic              err_cfg,
  output logic              err_timeout,
  output logic              err_beat,
  output logic [15:0]       beat_count,
  output logic [15:0]       layers_done
);

  state_t           state, state_n;
  cmd_t             wr_cmd, head;
  logic             fifo_full, fifo_empty, push, pop, legal;
  logic [EXP_W-1:0] exp_beats, bcnt, bcnt_inc, tlast_pos;
  logic [1:0]       tlast_cnt;
  logic [31:0]      wait_cnt;
  logic             beat_fire, set_cfg, set_to, set_beat;

  assign wr_cmd    = '{flen: cmd_flen, in_channel: cmd_in_channel};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_LOAD);
  assign legal     = cmd_legal(head);
  assign busy      = (state != S_IDLE);

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_q (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (wr_cmd),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign beat_fire = mon_tvalid && mon_tready &&
                     (state inside {S_START, S_WAIT_DONE, S_RELEASE});
  assign bcnt_inc  = (bcnt == '1) ? bcnt : bcnt + 1'b1;

  assign set_cfg  = (state == S_LOAD) && !legal;
  assign set_to   = (state == S_WAIT_DONE) && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
  // tlast must appear exactly once and sit on the final counted beat.
  assign set_beat = (state == S_REPORT) &&
                    ((bcnt != exp_beats) || (tlast_cnt != 2'd1) || (tlast_pos != bcnt));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (!fifo_empty) state_n = S_LOAD;
      S_LOAD:      state_n = legal ? S_START : S_IDLE;
      S_START:     state_n = S_WAIT_DONE;
      S_WAIT_DONE: if (pool_done) state_n = S_RELEASE;
      S_RELEASE:   if (!pool_done) state_n = S_REPORT;
      S_REPORT:    state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pool_start  <= 1'b0;
      flen        <= '0;
      in_channel  <= '0;
      exp_beats   <= '0;
      bcnt        <= '0;
      tlast_pos   <= '0;
      tlast_cnt   <= '0;
      wait_cnt    <= '0;
      irq         <= 1'b0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
      err_beat    <= 1'b0;
      beat_count  <= '0;
      layers_done <= '0;
    end else begin
      irq <= set_cfg || ((state == S_RELEASE) && !pool_done);

      if ((state == S_LOAD) && legal) begin
        flen       <= head.flen;
        in_channel <= head.in_channel;
        exp_beats  <= calc_expected(head);
        pool_start <= 1'b1;
      end else if ((state == S_WAIT_DONE) && pool_done) begin
        pool_start <= 1'b0;
      end

      if (state == S_LOAD) begin
        bcnt      <= '0;
        tlast_pos <= '0;
        tlast_cnt <= '0;
        wait_cnt  <= '0;
      end else begin
        if (beat_fire) begin
          bcnt <= bcnt_inc;
          if (mon_tlast) begin
            tlast_pos <= bcnt_inc;
            if (tlast_cnt != 2'd3) tlast_cnt <= tlast_cnt + 1'b1;
          end
        end
        if ((state == S_WAIT_DONE) && (wait_cnt < 32'(TIMEOUT_CYCLES)))
          wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == S_REPORT) begin
        beat_count  <= bcnt;
        layers_done <= layers_done + 1'b1;
      end

      // A set event in the same cycle as err_clr keeps the flag.
      err_cfg     <= set_cfg  || (err_cfg     && !err_clr);
      err_timeout <= set_to   || (err_timeout && !err_clr);
      err_beat    <= set_beat || (err_beat    && !err_clr);
    end
  end

endmodule
